axis_pixel_packer: RTL and testbench

// - Downstream of the image-processing top: consumes its 8-bit filtered pixel AXI-Stream.
// - Packs 4 consecutive pixels into one 32-bit AXI-Stream word for the DMA write channel.
// - Asserts tlast on the word holding the final pixel of each frame.
// - Emits a one-cycle frame-done pulse when that word is transferred.

---
 rtl/axis_pixel_packer.sv | 113 +++++++++++
 tb/tb_axis_pixel_packer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_pixel_packer.sv
// axis_pixel_packer: packs four 8-bit AXIS pixels into one 32-bit AXIS word, tlast on the frame's final word.
// Optional early frame close via i_flush when PACKER_FLUSH_EN is defined.
module axis_pixel_packer #(
    parameter int PIXELS_PER_FRAME = 262144,
    parameter int CNT_W            = 18
) (
    input  logic             axi_clk,
    input  logic             axi_reset_n,
    input  logic             s_axis_tvalid,
    input  logic [7:0]       s_axis_tdata,
    output logic             s_axis_tready,
    output logic             m_axis_tvalid,
    output logic [31:0]      m_axis_tdata,
    output logic [3:0]       m_axis_tkeep,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    input  logic             i_flush,
    output logic             o_frame_done,
    output logic [CNT_W-1:0] o_word_count
);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(PIXELS_PER_FRAME / 4 - 1);

    logic [1:0]       lane_q, lane_d;
    logic [23:0]      pix_q, pix_d;
    logic [31:0]      data_q, data_d;
    logic             valid_q, valid_d, last_q, last_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d, wcnt_hs;
    logic             acc, drain, out_free;

    assign out_free = !valid_q | m_axis_tready;
    assign drain    = valid_q & m_axis_tready;
    assign acc      = s_axis_tvalid & s_axis_tready;

    assign m_axis_tvalid = valid_q;
    assign m_axis_tdata  = data_q;
    assign m_axis_tlast  = last_q;
    assign o_frame_done  = drain & last_q;
    assign o_word_count  = wcnt_q;

`ifdef PACKER_FLUSH_EN
    logic       flush_q, flush_d, flush_go;
    logic [3:0] keep_q, keep_d;
    assign flush_go      = flush_q & out_free;
    assign s_axis_tready = ((lane_q != 2'd3) | out_free) & !flush_q;
    assign m_axis_tkeep  = keep_q;
`else
    logic unused_flush;
    assign unused_flush  = i_flush;
    assign s_axis_tready = (lane_q != 2'd3) | out_free;
    assign m_axis_tkeep  = 4'hF;
`endif

    always_comb begin
        lane_d  = acc ? lane_q + 2'd1 : lane_q;
        pix_d   = pix_q;
        if (acc && lane_q == 2'd0) pix_d[7:0]   = s_axis_tdata;
        if (acc && lane_q == 2'd1) pix_d[15:8]  = s_axis_tdata;
        if (acc && lane_q == 2'd2) pix_d[23:16] = s_axis_tdata;
        // counter value after this cycle's drain is the index of any word loaded now
        wcnt_hs = drain ? (last_q ? '0 : wcnt_q + 1'b1) : wcnt_q;
        wcnt_d  = wcnt_hs;
        valid_d = drain ? 1'b0 : valid_q;
        last_d  = drain ? 1'b0 : last_q;
        data_d  = data_q;
        if (acc && lane_q == 2'd3) begin
            valid_d = 1'b1;
            data_d  = {s_axis_tdata, pix_q};
            last_d  = (wcnt_hs == LAST_WORD);
        end
`ifdef PACKER_FLUSH_EN
        flush_d = flush_q | i_flush;
        keep_d  = (acc && lane_q == 2'd3) ? 4'hF : keep_q;
        if (flush_go) begin
            flush_d = 1'b0;
            lane_d  = 2'd0;
            wcnt_d  = '0;
            if (lane_q != 2'd0) begin
                valid_d = 1'b1;
                last_d  = 1'b1;
                data_d  = lane_q == 2'd1 ? {24'h0, pix_q[7:0]} :
                          lane_q == 2'd2 ? {16'h0, pix_q[15:0]} : {8'h0, pix_q};
                keep_d  = lane_q == 2'd1 ? 4'h1 : lane_q == 2'd2 ? 4'h3 : 4'h7;
            end
        end
`endif
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            lane_q  <= '0;
            pix_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            wcnt_q  <= '0;
`ifdef PACKER_FLUSH_EN
            flush_q <= 1'b0;
            keep_q  <= '0;
`endif
        end else begin
            lane_q  <= lane_d;
            pix_q   <= pix_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            wcnt_q  <= wcnt_d;
`ifdef PACKER_FLUSH_EN
            flush_q <= flush_d;
            keep_q  <= keep_d;
`endif
        end
    end
endmodule

// File: tb/tb_axis_pixel_packer.sv
// tb_axis_pixel_packer: directed bench for axis_pixel_packer with an 8-pixel frame.
// Flush scenarios run only when PACKER_FLUSH_EN is defined.
module tb_axis_pixel_packer;
    logic        clk = 1'b0;
    logic        axi_reset_n;
    logic        s_tvalid, s_tready, m_tvalid, m_tlast, m_tready, i_flush, done;
    logic [7:0]  s_tdata;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic [1:0]  wcount;

    int          tests = 0, fails = 0, done_cnt = 0;
    logic [31:0] wq[$];
    logic        lq[$];

    axis_pixel_packer #(.PIXELS_PER_FRAME(8), .CNT_W(2)) dut (
        .axi_clk(clk), .axi_reset_n(axi_reset_n),
        .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tready(s_tready),
        .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
        .m_axis_tlast(m_tlast), .m_axis_tready(m_tready), .i_flush(i_flush),
        .o_frame_done(done), .o_word_count(wcount)
    );

    always #5 clk = ~clk;

    // handshakes are observed on the falling edge, ahead of the rising edge that completes them
    always @(negedge clk) begin
        if (axi_reset_n) begin
            if (m_tvalid && m_tready) begin
                wq.push_back(m_tdata);
                lq.push_back(m_tlast);
            end
            if (done) done_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] px);
        s_tvalid = 1'b1;
        s_tdata  = px;
        cyc();
        s_tvalid = 1'b0;
    endtask

    initial begin
        int base, dbase, sent, budget;
        logic hs;
        logic [31:0] exp;
        axi_reset_n = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0; i_flush = 1'b0;
        repeat (3) cyc();
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_s_tready", s_tready, 1);
        check("rst_wcount", wcount, 0);
        check("rst_done", done, 0);
        axi_reset_n = 1'b1;
        cyc();

        // single frame, back-to-back pixels, downstream always ready
        base = wq.size(); dbase = done_cnt;
        m_tready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 8'(i);
            cyc();
            check("lat_valid", m_tvalid, (i == 4 || i == 8));
            check("lat_last", m_tlast, (i == 8));
        end
        check("full_keep", m_tkeep, 4'hF);
        s_tvalid = 1'b0;
        cyc(); cyc();
        check("f1_words", wq.size() - base, 2);
        check("f1_w0", wq[base], 32'h04030201);
        check("f1_l0", lq[base], 0);
        check("f1_w1", wq[base+1], 32'h08070605);
        check("f1_l1", lq[base+1], 1);
        check("f1_done", done_cnt - dbase, 1);
        check("f1_wcount", wcount, 0);

        // backpressure: word held, three more pixels fill lanes, then stall
        base = wq.size(); dbase = done_cnt;
        m_tready = 1'b0;
        for (int i = 0; i < 7; i++) send(8'h11 + 8'(i));
        check("bp_valid", m_tvalid, 1);
        check("bp_data", m_tdata, 32'h14131211);
        s_tvalid = 1'b1; s_tdata = 8'h18;
        #1;
        check("bp_stall", s_tready, 0);
        cyc(); cyc();
        check("bp_hold", m_tdata, 32'h14131211);
        check("bp_stall2", s_tready, 0);
        m_tready = 1'b1;
        #1;
        check("bp_comb_ready", s_tready, 1);
        cyc();
        s_tvalid = 1'b0;
        check("bp_next_valid", m_tvalid, 1);
        check("bp_next_data", m_tdata, 32'h18171615);
        check("bp_next_last", m_tlast, 1);
        cyc();
        check("bp_words", wq.size() - base, 2);
        check("bp_w0", wq[base], 32'h14131211);
        check("bp_done", done_cnt - dbase, 1);
        check("bp_wcount", wcount, 0);

        // two frames with random gaps on both sides
        base = wq.size(); dbase = done_cnt;
        sent = 0; budget = 0;
        while ((wq.size() - base < 4) && budget < 2000) begin
            if (sent < 16) begin
                s_tvalid = (s_tvalid && !hs) ? 1'b1 : 1'($urandom_range(0, 1));
                s_tdata  = 8'h30 + 8'(sent);
            end else s_tvalid = 1'b0;
            m_tready = 1'($urandom_range(0, 1));
            #1;
            hs = s_tvalid & s_tready;
            cyc();
            if (hs) sent++;
            budget++;
        end
        s_tvalid = 1'b0; m_tready = 1'b1;
        cyc();
        check("rnd_budget", (budget < 2000), 1);
        check("rnd_sent", sent, 16);
        check("rnd_words", wq.size() - base, 4);
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 4; b++) exp[8*b +: 8] = 8'h30 + 8'(4*k + b);
            check("rnd_word", wq[base+k], exp);
            check("rnd_last", lq[base+k], (k == 1 || k == 3));
        end
        check("rnd_done", done_cnt - dbase, 2);
        check("rnd_wcount", wcount, 0);

        // reset in the middle of a frame with a held word
        m_tready = 1'b0;
        for (int i = 0; i < 6; i++) send(8'h41 + 8'(i));
        check("mid_valid_pre", m_tvalid, 1);
        axi_reset_n = 1'b0;
        #1;
        check("mid_rst_valid", m_tvalid, 0);
        check("mid_rst_data", m_tdata, 0);
        check("mid_rst_ready", s_tready, 1);
        check("mid_rst_wcount", wcount, 0);
        cyc();
        axi_reset_n = 1'b1;
        m_tready = 1'b1;
        cyc();
        base = wq.size(); dbase = done_cnt;
        for (int i = 0; i < 8; i++) send(8'h51 + 8'(i));
        cyc(); cyc();
        check("mid_words", wq.size() - base, 2);
        check("mid_w0", wq[base], 32'h54535251);
        check("mid_l0", lq[base], 0);
        check("mid_w1", wq[base+1], 32'h58575655);
        check("mid_l1", lq[base+1], 1);
        check("mid_done", done_cnt - dbase, 1);

`ifdef PACKER_FLUSH_EN
        base = wq.size(); dbase = done_cnt;
        send(8'hAA);
        send(8'hBB);
        i_flush = 1'b1;
        cyc();
        i_flush = 1'b0;
        check("fl_ready_low", s_tready, 0);
        cyc();
        check("fl_valid", m_tvalid, 1);
        check("fl_data", m_tdata, 32'h0000BBAA);
        check("fl_keep", m_tkeep, 4'b0011);
        check("fl_last", m_tlast, 1);
        cyc();
        check("fl_wcount", wcount, 0);
        check("fl_done", done_cnt - dbase, 1);
        check("fl_words", wq.size() - base, 1);
        i_flush = 1'b1;
        cyc();
        i_flush = 1'b0;
        check("fl0_ready_low", s_tready, 0);
        check("fl0_valid", m_tvalid, 0);
        cyc();
        check("fl0_ready_high", s_tready, 1);
        check("fl0_valid2", m_tvalid, 0);
        check("fl0_words", wq.size() - base, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
